control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Instruction sequencer and decoder that sits directly upstream of the datapath.
- Holds the PC, instruction register and a latched NZCV flag register.
- Fetches 32-bit LEGv8 instructions and decodes them into the datapath's 25-bit control word plus 64-bit immediate.
- Resolves branches internally using the datapath ALU status.
- Two-state fetch/execute machine, plus a terminal HALT state for unsupported encodings.

Parameters:
PC_RESET, 64'h0, PC value loaded on reset
PC_STEP, 64'd4, byte increment per sequential instruction

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low; clears all state immediately
instruction  input  32  instruction memory read data for address pc, valid during FETCH
status  input  4  datapath ALU status {V,C,N,Z}, combinational from current control word
pc  output  64  instruction fetch byte address
controlword  output  25  {alu_en, b_sel, fs[4:0], sel_a[4:0], sel_b[4:0], dest[4:0], reg_write, ram_en, ram_write}, MSB first
immediate  output  64  extended immediate presented to ALU B input
halted  output  1  high while in HALT

Behaviour:
- Reset (reset low, asynchronous): state=FETCH, pc=PC_RESET, ir=0, flags=4'b0000, controlword=0, immediate=0, halted=0.
- FETCH (1 cycle):
  - ir<=instruction; controlword all zero, so no register or RAM writes.
  - Next state EXEC.
- EXEC (1 cycle):
  - controlword and immediate are decoded combinationally from ir.
  - On the rising edge: pc updates, flags update if the instruction is ADDS/SUBS, next state FETCH.
  - Unrecognised opcode: next state HALT, pc unchanged.
- HALT: controlword=0, halted=1, no state changes until reset.
- Every instruction therefore takes exactly 2 cycles. Load data reaches the register file on the EXEC closing edge, because the RAM reads on the falling edge.
- ALU fs encoding is {op[2:0], b_invert, a_invert}, with cin=fs[1]:
  - AND=00000, ORR=00100, ADD=01000, SUB=01010.
- Decode (Rd=ir[4:0], Rn=ir[9:5], Rm=ir[20:16], Rt=ir[4:0]):
  - ADD/SUB/AND/ORR/ADDS/SUBS (11-bit opcodes 10001011000/11001011000/10001010000/10101010000/10101011000/11101011000):
    - alu_en=1, b_sel=0, sel_a=Rn, sel_b=Rm, dest=Rd, reg_write=1.
  - ADDI/SUBI/ANDI/ORRI (10-bit opcodes 1001000100/1101000100/1001001000/1011001000):
    - b_sel=1, immediate=zero-extended ir[21:10]; otherwise as R-type.
  - LDUR (11111000010):
    - alu_en=0, b_sel=1, fs=ADD, sel_a=Rn, dest=Rt, reg_write=1, ram_en=1.
    - immediate=sign-extended ir[20:12].
  - CBZ/CBNZ (8-bit opcodes 10110100/10110101):
    - b_sel=1, immediate=0, fs=ADD, sel_a=Rt, no writes.
    - Taken when status Z=1 (CBZ) or Z=0 (CBNZ).
  - B (6-bit opcode 000101): always taken, controlword=0.
  - B.cond (01010100): controlword=0; condition ir[3:0] is evaluated against the latched flags.
    - Codes EQ..AL (0x0-0xE) follow standard ARM semantics; 0xF counts as never taken.
- Branch target = pc + (sign-extended offset << 2):
  - offset is ir[25:0] for B, ir[23:5] for CB*/B.cond.
  - Arithmetic is mod 2^64; wrap-around is permitted.
  - Not taken: pc+PC_STEP.
- Flags latch {V,C,N,Z}=status only at the EXEC edge of ADDS/SUBS; all other instructions hold them.
- Opcode matching is by longest-prefix priority: 11-bit, then 10-bit, then 8-bit, then 6-bit.

Decomposition:
- Shared package control_pkg holds:
  - fs constants (FS_AND, FS_ORR, FS_ADD, FS_SUB);
  - controlword field positions;
  - opcode constants;
  - state enum {FETCH, EXEC, HALT};
  - condition code constants.
- One natural sub-module: condition_check, a combinational function of (cond[3:0], flags[3:0]) returning taken.

Test Plan:
- Reset low mid-EXEC with pc=0x40 -> pc=0 and controlword=0 immediately, with no clock edge; after reset release, first FETCH of address 0.
- ADDI X1,X31,#5 (0x910017E1) in EXEC -> controlword: alu_en=1, b_sel=1, fs=01000, sel_a=31, dest=1, reg_write=1; immediate=5; pc 0->4 after 2 cycles.
- LDUR X2,[X1,#-8] (0xF85F8022) -> immediate=0xFFFF_FFFF_FFFF_FFF8, ram_en=1, alu_en=0, dest=2.
- CBZ X3,+3 at pc=0x10 with status Z=1 -> pc=0x1C; the same case with Z=0 -> pc=0x14.
- SUBS with status=4'b0001, then B.EQ -8 at pc=0x20 -> pc=0x00; then B.NE with the same flags -> pc+4; an intervening ADD with status 0 does not change flags.
- Instruction 0x00000000 -> HALT: halted=1, controlword=0, pc frozen across 10 cycles; cleared only by reset.

Source files
------------

// File: rtl/control_pkg.sv
// Shared definitions for the LEGv8 control unit: control-word layout, ALU
// function selects, opcodes, FSM states and branch condition codes.
package control_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned IW    = 32;
  localparam int unsigned CW_W  = 25;
  localparam int unsigned FS_W  = 5;
  localparam int unsigned REG_W = 5;
  localparam int unsigned NZCV_W = 4;

  // ALU function select {op[2:0], b_invert, a_invert}; carry-in is fs[1]
  localparam logic [FS_W-1:0] FS_AND = 5'b00000;
  localparam logic [FS_W-1:0] FS_ORR = 5'b00100;
  localparam logic [FS_W-1:0] FS_ADD = 5'b01000;
  localparam logic [FS_W-1:0] FS_SUB = 5'b01010;

  // Control-word bit positions, MSB first
  localparam int unsigned CW_ALU_EN    = 24;
  localparam int unsigned CW_B_SEL     = 23;
  localparam int unsigned CW_FS_LSB    = 18;
  localparam int unsigned CW_SEL_A_LSB = 13;
  localparam int unsigned CW_SEL_B_LSB = 8;
  localparam int unsigned CW_DEST_LSB  = 3;
  localparam int unsigned CW_REG_WRITE = 2;
  localparam int unsigned CW_RAM_EN    = 1;
  localparam int unsigned CW_RAM_WRITE = 0;

  typedef struct packed {
    logic             alu_en;
    logic             b_sel;
    logic [FS_W-1:0]  fs;
    logic [REG_W-1:0] sel_a;
    logic [REG_W-1:0] sel_b;
    logic [REG_W-1:0] dest;
    logic             reg_write;
    logic             ram_en;
    logic             ram_write;
  } ctrl_word_t;

  // 11-bit opcodes, ir[31:21]
  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_ADDS = 11'b10101011000;
  localparam logic [10:0] OP_SUBS = 11'b11101011000;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  // 10-bit opcodes, ir[31:22]
  localparam logic [9:0]  OP_ADDI = 10'b1001000100;
  localparam logic [9:0]  OP_SUBI = 10'b1101000100;
  localparam logic [9:0]  OP_ANDI = 10'b1001001000;
  localparam logic [9:0]  OP_ORRI = 10'b1011001000;
  // 8-bit opcodes, ir[31:24]
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_CBNZ  = 8'b10110101;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  // 6-bit opcode, ir[31:26]
  localparam logic [5:0]  OP_B     = 6'b000101;

  // Flag bit positions within {V,C,N,Z}
  localparam int unsigned FLAG_Z = 0;
  localparam int unsigned FLAG_N = 1;
  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_V = 3;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_HS = 4'h2;
  localparam logic [3:0] COND_LO = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;
  localparam logic [3:0] COND_NV = 4'hF;

endpackage

// File: rtl/control_unit_condition_check.sv
// Evaluates a B.cond condition code against latched {V,C,N,Z} flags.
// Ports: cond - condition code ir[3:0]; flags - {V,C,N,Z};
//        taken_c - combinational branch-taken result.
module condition_check
  import control_pkg::*;
(
  input  logic [3:0]        cond,
  input  logic [NZCV_W-1:0] flags,
  output logic              taken_c
);

  logic v, c, n, z;

  assign v = flags[FLAG_V];
  assign c = flags[FLAG_C];
  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];

  // Standard ARM condition semantics; NV is treated as never taken
  always_comb begin
    taken_c = 1'b0;
    case (cond)
      COND_EQ: taken_c = z;
      COND_NE: taken_c = ~z;
      COND_HS: taken_c = c;
      COND_LO: taken_c = ~c;
      COND_MI: taken_c = n;
      COND_PL: taken_c = ~n;
      COND_VS: taken_c = v;
      COND_VC: taken_c = ~v;
      COND_HI: taken_c = c & ~z;
      COND_LS: taken_c = ~(c & ~z);
      COND_GE: taken_c = (n == v);
      COND_LT: taken_c = (n != v);
      COND_GT: taken_c = ~z & (n == v);
      COND_LE: taken_c = ~(~z & (n == v));
      COND_AL: taken_c = 1'b1;
      COND_NV: taken_c = 1'b0;
      default: taken_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// LEGv8 fetch/execute sequencer: holds pc, ir and NZCV flags, decodes the
// instruction register into the datapath control word and immediate, and
// resolves branches internally.
// Ports: clock, reset (async active-low); instruction - imem data at pc;
//        status - datapath {V,C,N,Z}; pc - fetch address; controlword -
//        25-bit datapath control; immediate - ALU B immediate; halted.
module control_unit
  import control_pkg::*;
#(
  parameter logic [XLEN-1:0] PC_RESET = 64'h0,
  parameter logic [XLEN-1:0] PC_STEP  = 64'd4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [IW-1:0]     instruction,
  input  logic [NZCV_W-1:0] status,
  output logic [XLEN-1:0]   pc,
  output logic [CW_W-1:0]   controlword,
  output logic [XLEN-1:0]   immediate,
  output logic              halted
);

  state_t              state_q, state_d;
  logic [XLEN-1:0]     pc_q, pc_d;
  logic [IW-1:0]       ir_q, ir_d;
  logic [NZCV_W-1:0]   flags_q, flags_d;

  ctrl_word_t          dec_cw;
  logic [XLEN-1:0]     dec_imm;
  logic                dec_valid;
  logic                sets_flags;
  logic                br_taken;
  logic [XLEN-1:0]     br_offset;
  logic                r_hit, i_hit;
  logic [FS_W-1:0]     r_fs, i_fs;
  logic                cond_taken_c;
  logic [XLEN-1:0]     off_b, off_c;

  condition_check u_condition_check (
    .cond    (ir_q[3:0]),
    .flags   (flags_q),
    .taken_c (cond_taken_c)
  );

  // Word offsets sign-extended and scaled to bytes
  assign off_b = {{36{ir_q[25]}}, ir_q[25:0], 2'b00};
  assign off_c = {{43{ir_q[23]}}, ir_q[23:5], 2'b00};

  // Arithmetic/logic opcode classes: 11-bit register form, 10-bit immediate form
  always_comb begin
    r_hit      = 1'b1;
    r_fs       = FS_ADD;
    sets_flags = 1'b0;
    case (ir_q[31:21])
      OP_ADD:  r_fs = FS_ADD;
      OP_SUB:  r_fs = FS_SUB;
      OP_AND:  r_fs = FS_AND;
      OP_ORR:  r_fs = FS_ORR;
      OP_ADDS: begin r_fs = FS_ADD; sets_flags = 1'b1; end
      OP_SUBS: begin r_fs = FS_SUB; sets_flags = 1'b1; end
      default: r_hit = 1'b0;
    endcase

    i_hit = 1'b1;
    i_fs  = FS_ADD;
    case (ir_q[31:22])
      OP_ADDI: i_fs = FS_ADD;
      OP_SUBI: i_fs = FS_SUB;
      OP_ANDI: i_fs = FS_AND;
      OP_ORRI: i_fs = FS_ORR;
      default: i_hit = 1'b0;
    endcase
  end

  // Decode with longest-prefix priority: 11-bit, 10-bit, 8-bit, 6-bit
  always_comb begin
    dec_cw    = '0;
    dec_imm   = '0;
    dec_valid = 1'b0;
    br_taken  = 1'b0;
    br_offset = '0;
    if (r_hit) begin
      dec_valid        = 1'b1;
      dec_cw.alu_en    = 1'b1;
      dec_cw.fs        = r_fs;
      dec_cw.sel_a     = ir_q[9:5];
      dec_cw.sel_b     = ir_q[20:16];
      dec_cw.dest      = ir_q[4:0];
      dec_cw.reg_write = 1'b1;
    end else if (ir_q[31:21] == OP_LDUR) begin
      dec_valid        = 1'b1;
      dec_cw.b_sel     = 1'b1;
      dec_cw.fs        = FS_ADD;
      dec_cw.sel_a     = ir_q[9:5];
      dec_cw.dest      = ir_q[4:0];
      dec_cw.reg_write = 1'b1;
      dec_cw.ram_en    = 1'b1;
      dec_imm          = {{55{ir_q[20]}}, ir_q[20:12]};
    end else if (i_hit) begin
      dec_valid        = 1'b1;
      dec_cw.alu_en    = 1'b1;
      dec_cw.b_sel     = 1'b1;
      dec_cw.fs        = i_fs;
      dec_cw.sel_a     = ir_q[9:5];
      dec_cw.sel_b     = ir_q[20:16];
      dec_cw.dest      = ir_q[4:0];
      dec_cw.reg_write = 1'b1;
      dec_imm          = {52'd0, ir_q[21:10]};
    end else if ((ir_q[31:24] == OP_CBZ) || (ir_q[31:24] == OP_CBNZ)) begin
      // ALU passes Rt + 0 so the datapath Z flag reflects Rt == 0
      dec_valid    = 1'b1;
      dec_cw.b_sel = 1'b1;
      dec_cw.fs    = FS_ADD;
      dec_cw.sel_a = ir_q[4:0];
      br_taken     = (ir_q[31:24] == OP_CBZ) ? status[FLAG_Z] : ~status[FLAG_Z];
      br_offset    = off_c;
    end else if (ir_q[31:24] == OP_BCOND) begin
      dec_valid = 1'b1;
      br_taken  = cond_taken_c;
      br_offset = off_c;
    end else if (ir_q[31:26] == OP_B) begin
      dec_valid = 1'b1;
      br_taken  = 1'b1;
      br_offset = off_b;
    end
  end

  // Next-state logic: fetch latches ir, execute advances pc and flags
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    flags_d = flags_q;
    case (state_q)
      FETCH: begin
        ir_d    = instruction;
        state_d = EXEC;
      end
      EXEC: begin
        if (dec_valid) begin
          pc_d    = br_taken ? (pc_q + br_offset) : (pc_q + PC_STEP);
          state_d = FETCH;
          if (sets_flags) begin
            flags_d = status;
          end
        end else begin
          state_d = HALT;
        end
      end
      HALT:    state_d = HALT;
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= PC_RESET;
      ir_q    <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      flags_q <= flags_d;
    end
  end

  // Decoded fields drive the datapath only during EXEC
  assign controlword = (state_q == EXEC) ? CW_W'(dec_cw) : '0;
  assign immediate   = (state_q == EXEC) ? dec_imm : '0;
  assign pc          = pc_q;
  assign halted      = (state_q == HALT);

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: expectations are queued when an
// instruction is driven and popped when the DUT reaches EXEC / next FETCH.
module tb_control_unit;
  import control_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] instruction = 32'h0;
  logic [3:0]  status = 4'h0;
  logic [63:0] pc;
  logic [24:0] controlword;
  logic [63:0] immediate;
  logic        halted;

  control_unit dut (
    .clock       (clock),
    .reset       (reset),
    .instruction (instruction),
    .status      (status),
    .pc          (pc),
    .controlword (controlword),
    .immediate   (immediate),
    .halted      (halted)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    int unsigned what;   // 0 masked controlword, 1 immediate, 2 halted
    logic [63:0] mask;
    logic [63:0] val;
  } exp_t;

  exp_t exec_q[$];
  exp_t pc_q[$];
  int   checks = 0;
  int   errors = 0;

  localparam logic [63:0] M_ALL  = 64'h1FF_FFFF;
  localparam logic [63:0] M_ALU  = 64'd1 << CW_ALU_EN;
  localparam logic [63:0] M_BSEL = 64'd1 << CW_B_SEL;
  localparam logic [63:0] M_FS   = 64'h1F << CW_FS_LSB;
  localparam logic [63:0] M_SELA = 64'h1F << CW_SEL_A_LSB;
  localparam logic [63:0] M_SELB = 64'h1F << CW_SEL_B_LSB;
  localparam logic [63:0] M_DEST = 64'h1F << CW_DEST_LSB;
  localparam logic [63:0] M_WR   = (64'd1 << CW_REG_WRITE) | (64'd1 << CW_RAM_EN) |
                                   (64'd1 << CW_RAM_WRITE);

  function automatic logic [24:0] mk_cw(input logic alu, input logic bsel,
                                        input logic [4:0] fs, input logic [4:0] sa,
                                        input logic [4:0] sb, input logic [4:0] dest,
                                        input logic rw, input logic re, input logic rwr);
    return {alu, bsel, fs, sa, sb, dest, rw, re, rwr};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic exp_cw(input string tag, input logic [63:0] mask, input logic [24:0] val);
    exp_t e;
    e.tag = tag; e.what = 0; e.mask = mask; e.val = 64'(val) & mask;
    exec_q.push_back(e);
  endtask

  task automatic exp_imm(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag; e.what = 1; e.mask = '1; e.val = val;
    exec_q.push_back(e);
  endtask

  task automatic exp_pc(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag; e.what = 2; e.mask = '1; e.val = val;
    pc_q.push_back(e);
  endtask

  // Called at a negedge in FETCH; returns at the negedge of the next FETCH
  task automatic run(input logic [31:0] ins, input logic [3:0] st);
    exp_t e;
    instruction = ins;
    status      = st;
    @(negedge clock);
    #1;
    while (exec_q.size() > 0) begin
      e = exec_q.pop_front();
      if (e.what == 0) chk(e.tag, 64'(controlword) & e.mask, e.val);
      else             chk(e.tag, immediate, e.val);
    end
    chk("exec_not_halted", 64'(halted), 64'd0);
    @(negedge clock);
    while (pc_q.size() > 0) begin
      e = pc_q.pop_front();
      chk(e.tag, pc, e.val);
    end
  endtask

  initial begin
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst_pc", pc, 64'h0);
    chk("rst_cw", 64'(controlword), 64'h0);
    chk("rst_imm", immediate, 64'h0);
    chk("rst_halted", 64'(halted), 64'd0);
    reset = 1'b1;

    // ADDI X1,X31,#5 at 0
    exp_cw("addi_cw", M_ALL, mk_cw(1, 1, 5'b01000, 5'd31, 5'd0, 5'd1, 1, 0, 0));
    exp_imm("addi_imm", 64'd5);
    exp_pc("addi_pc", 64'h4);
    run(32'h910017E1, 4'h0);

    // LDUR X2,[X1,#-8] at 4
    exp_cw("ldur_cw", M_ALU | M_BSEL | M_FS | M_SELA | M_DEST | M_WR,
           mk_cw(0, 1, 5'b01000, 5'd1, 5'd0, 5'd2, 1, 1, 0));
    exp_imm("ldur_imm", 64'hFFFF_FFFF_FFFF_FFF8);
    exp_pc("ldur_pc", 64'h8);
    run(32'hF85F8022, 4'h0);

    // B +2 at 8
    exp_cw("b_cw", M_ALL, 25'd0);
    exp_pc("b_fwd_pc", 64'h10);
    run(32'h14000002, 4'h0);

    // CBZ X3,+3 at 0x10, Z=1: taken
    exp_cw("cbz_cw", M_BSEL | M_FS | M_SELA | M_WR,
           mk_cw(0, 1, 5'b01000, 5'd3, 5'd0, 5'd0, 0, 0, 0));
    exp_imm("cbz_imm", 64'h0);
    exp_pc("cbz_taken_pc", 64'h1C);
    run(32'hB4000063, 4'b0001);

    // B -3 back to 0x10
    exp_pc("b_back_pc", 64'h10);
    run(32'h17FFFFFD, 4'h0);

    // CBZ X3,+3 at 0x10, Z=0: not taken
    exp_pc("cbz_nt_pc", 64'h14);
    run(32'hB4000063, 4'b0000);

    // SUBS X0,X1,X2 with status Z=1 latches flags
    exp_cw("subs_cw", M_ALL, mk_cw(1, 0, 5'b01010, 5'd1, 5'd2, 5'd0, 1, 0, 0));
    exp_pc("subs_pc", 64'h18);
    run(32'hEB020020, 4'b0001);

    // ADD X3,X1,X2 with status 0 must not disturb flags
    exp_cw("add_cw", M_ALL, mk_cw(1, 0, 5'b01000, 5'd1, 5'd2, 5'd3, 1, 0, 0));
    exp_pc("add_pc", 64'h1C);
    run(32'h8B020023, 4'b0000);

    // B.NE +5 at 0x1C with Z=1: not taken
    exp_cw("bne_cw", M_ALL, 25'd0);
    exp_pc("bne_nt_pc", 64'h20);
    run(32'h540000A1, 4'b0000);

    // B.EQ -8 at 0x20: taken to 0
    exp_pc("beq_taken_pc", 64'h0);
    run(32'h54FFFF00, 4'b0000);

    // B.NV +4 at 0: never taken
    exp_pc("bnv_pc", 64'h4);
    run(32'h5400008F, 4'b0000);

    // B.GE +2 at 4 with N=V=0: taken
    exp_pc("bge_pc", 64'hC);
    run(32'h5400004A, 4'b0000);

    // B +13 at 0xC to 0x40
    exp_pc("b_to_40_pc", 64'h40);
    run(32'h1400000D, 4'h0);

    // Asynchronous reset in the middle of EXEC at 0x40
    instruction = 32'h8B020023;
    @(posedge clock);
    #2;
    chk("mid_exec_pc", pc, 64'h40);
    chk("mid_exec_cw", 64'(controlword),
        64'(mk_cw(1, 0, 5'b01000, 5'd1, 5'd2, 5'd3, 1, 0, 0)));
    reset = 1'b0;
    #1;
    chk("async_rst_pc", pc, 64'h0);
    chk("async_rst_cw", 64'(controlword), 64'h0);
    @(negedge clock);
    reset = 1'b1;
    chk("post_rst_pc", pc, 64'h0);
    chk("post_rst_cw", 64'(controlword), 64'h0);

    // First instruction after reset comes from address 0
    exp_cw("addi2_cw", M_ALL, mk_cw(1, 1, 5'b01000, 5'd31, 5'd0, 5'd1, 1, 0, 0));
    exp_pc("addi2_pc", 64'h4);
    run(32'h910017E1, 4'h0);

    // Unsupported encoding halts with pc frozen
    exp_cw("bad_cw", M_ALL, 25'd0);
    exp_pc("halt_pc", 64'h4);
    run(32'h00000000, 4'h0);
    chk("halt_flag", 64'(halted), 64'd1);
    instruction = 32'h910017E1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      chk("halt_hold_pc", pc, 64'h4);
      chk("halt_hold_flag", 64'(halted), 64'd1);
      chk("halt_hold_cw", 64'(controlword), 64'h0);
    end
    reset = 1'b0;
    #1;
    chk("halt_clear_flag", 64'(halted), 64'd0);
    chk("halt_clear_pc", pc, 64'h0);
    reset = 1'b1;
    @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
